zion_basic_circuit_lib_rr_load_arb: RTL and testbench
=====================================================

Name: zion_basic_circuit_lib_rr_load_arb

Overview:
- Round-robin arbiter plus one output holding register; N requesters share one enable-loaded register stage.
- Each cycle, at most one requester's word is loaded into the register, which then drives a downstream valid/ready port.
- Sits in front of shared datapath registers, e.g. config or CSR write paths fed by several masters.
- One-entry pipeline: full throughput when downstream is always ready.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2 or more.
- WIDTH, 8, data width per requester.
- INI_DATA, '0, reset value of oDat.
- IDX_W, $clog2(NUM_REQ), width of grant index; derived, never overridden.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- iReqVld  input  NUM_REQ  per-requester valid.
- oReqRdy  output  NUM_REQ  per-requester ready, one-hot or zero.
- iReqDat  input  NUM_REQ*WIDTH  packed data; requester i uses bits [i*WIDTH +: WIDTH].
- iReqLast  input  NUM_REQ  end-of-burst flag per requester; present only with ZION_RR_ARB_LOCK_EN.
- oVld  output  1  output register holds valid data.
- iRdy  input  1  downstream ready.
- oDat  output  WIDTH  registered data.
- oGntIdx  output  IDX_W  index of the requester whose data is in oDat.

Behaviour:
- Reset (async, rst=1):
  - oVld=0, oDat=INI_DATA, oGntIdx=0.
  - Round-robin pointer ptr=0; lock state cleared.
- Load enable: ld = (!oVld || iRdy) && winner_valid.
- Winner selection (combinational):
  - Winner is the first i with iReqVld[i]=1, searching ptr, ptr+1, … NUM_REQ-1, 0, … ptr-1.
  - winner_valid = |iReqVld.
- oReqRdy[i] = ld && (winner==i).
  - At most one bit set.
  - oReqRdy does not depend combinationally on iReqDat.
- On ld (next edge):
  - oDat <= winner's data; oGntIdx <= winner; oVld <= 1.
  - ptr <= (winner==NUM_REQ-1) ? 0 : winner+1.
- Downstream transfer is oVld && iRdy.
  - Transfer with no ld in the same cycle: oVld <= 0; oDat and oGntIdx hold their old values.
  - Transfer and ld in the same cycle: oVld stays 1; new data is loaded; no bubble.
- Stall (oVld && !iRdy): oDat, oGntIdx and ptr hold; all oReqRdy = 0.
- Latency: one cycle from the requester handshake to oVld.
- Requester rules:
  - A requester may drop iReqVld without a handshake; no penalty.
  - ptr changes only on ld.
- Fairness: every continuously-valid requester is granted within NUM_REQ loads.
- Reset asserted mid-operation: all state returns to reset values immediately; an in-flight word is discarded.
- Elaboration check: $error if NUM_REQ<2 or WIDTH<1; $finish when CHECK_ERR_EXIT is defined.

Optional Feature:
- Macro: ZION_RR_ARB_LOCK_EN.
- Defined:
  - The iReqLast port exists.
  - On ld with iReqLast[winner]=0: lock on the winner; ptr does not advance.
  - While locked, only the locked requester is eligible; other iReqVld are ignored.
  - ld with iReqLast=1 from the locked requester: releases the lock and advances ptr to winner+1.
  - A locked requester that deasserts iReqVld keeps the lock and blocks the others.
  - Reset clears the lock.
- Undefined: the iReqLast port is absent; every beat re-arbitrates as described in Behaviour.

Test Plan:
- Reset values: assert rst mid-stream with oVld=1 -> oVld=0, oDat=INI_DATA, oGntIdx=0 immediately, before any clock edge.
- Full throughput: NUM_REQ=4, all iReqVld=1, iRdy=1 held -> oGntIdx sequence 0,1,2,3,0,… with oVld=1 every cycle after the first.
- Back-pressure: iRdy=0 for 3 cycles with oVld=1 -> oDat and oGntIdx stable, oReqRdy=0; at iRdy=1, the next winner loads in the same cycle.
- Wrap-around: ptr=3, only requesters 1 and 3 valid -> grants 3 then 1; with only requester 1 valid -> consecutive grants to 1.
- Drain: a single request for data 0xA5 from requester 2 with iRdy=1 -> oVld=1, oDat=0xA5, oGntIdx=2 for exactly one cycle, then oVld=0.
- Lock (macro defined): requester 1 sends a 3-beat burst with iReqLast=0,0,1 while requester 0 is valid -> grants 1,1,1 then 0.

Source files
------------

// File: rtl/zion_basic_circuit_lib_rr_load_arb.sv
// Round-robin arbiter feeding one enable-loaded output register with a valid/ready port.
// Optional burst locking (iReqLast) is enabled by defining ZION_RR_ARB_LOCK_EN.
module zion_basic_circuit_lib_rr_load_arb #(
  parameter int                NUM_REQ  = 4,
  parameter int                WIDTH    = 8,
  parameter logic [WIDTH-1:0]  INI_DATA = '0,
  parameter int                IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       iReqVld,
  output logic [NUM_REQ-1:0]       oReqRdy,
  input  logic [NUM_REQ*WIDTH-1:0] iReqDat,
`ifdef ZION_RR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       iReqLast,
`endif
  output logic                     oVld,
  input  logic                     iRdy,
  output logic [WIDTH-1:0]         oDat,
  output logic [IDX_W-1:0]         oGntIdx
);

  if (NUM_REQ < 2 || WIDTH < 1) begin : g_param_err
`ifdef CHECK_ERR_EXIT
    $fatal(1, "zion_basic_circuit_lib_rr_load_arb: NUM_REQ must be >= 2 and WIDTH >= 1");
`else
    $error("zion_basic_circuit_lib_rr_load_arb: NUM_REQ must be >= 2 and WIDTH >= 1");
`endif
  end

  logic [IDX_W-1:0]   ptr, winner, ptr_nxt;
  logic [NUM_REQ-1:0] elig;
  logic               win_vld, ld;

`ifdef ZION_RR_ARB_LOCK_EN
  logic             locked;
  logic [IDX_W-1:0] lock_idx;

  // While a burst is open only the locked requester may win, even if it idles.
  always_comb begin
    elig = iReqVld;
    if (locked) elig = iReqVld & (NUM_REQ'(1) << lock_idx);
  end
`else
  assign elig = iReqVld;
`endif

  // Lowest eligible index at or above ptr wins; otherwise wrap to lowest overall.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (elig[i]) winner = IDX_W'(i);
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (elig[i] && IDX_W'(i) >= ptr) winner = IDX_W'(i);
  end

  assign win_vld = |elig;
  assign ld      = (!oVld || iRdy) && win_vld;
  assign ptr_nxt = (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rdy
    assign oReqRdy[g] = ld && (winner == IDX_W'(g));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oVld    <= 1'b0;
      oDat    <= INI_DATA;
      oGntIdx <= '0;
      ptr     <= '0;
`ifdef ZION_RR_ARB_LOCK_EN
      locked   <= 1'b0;
      lock_idx <= '0;
`endif
    end else if (ld) begin
      oVld    <= 1'b1;
      oDat    <= iReqDat[winner*WIDTH +: WIDTH];
      oGntIdx <= winner;
`ifdef ZION_RR_ARB_LOCK_EN
      if (!iReqLast[winner]) begin
        locked   <= 1'b1;
        lock_idx <= winner;
      end else begin
        locked <= 1'b0;
        ptr    <= ptr_nxt;
      end
`else
      ptr <= ptr_nxt;
`endif
    end else if (oVld && iRdy) begin
      oVld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zion_basic_circuit_lib_rr_load_arb.sv
// Directed bench with an expected-transfer queue for the round-robin load arbiter.
module tb_zion_basic_circuit_lib_rr_load_arb;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     iReqVld, oReqRdy;
  logic [N*W-1:0]   iReqDat;
`ifdef ZION_RR_ARB_LOCK_EN
  logic [N-1:0]     iReqLast;
`endif
  logic             oVld, iRdy;
  logic [W-1:0]     oDat;
  logic [IW-1:0]    oGntIdx;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  dat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   seed   = 0;

  always #5 clk = ~clk;

  zion_basic_circuit_lib_rr_load_arb #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .iReqVld (iReqVld),
    .oReqRdy (oReqRdy),
    .iReqDat (iReqDat),
`ifdef ZION_RR_ARB_LOCK_EN
    .iReqLast(iReqLast),
`endif
    .oVld    (oVld),
    .iRdy    (iRdy),
    .oDat    (oDat),
    .oGntIdx (oGntIdx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle starting at a negedge: drive inputs, check ready and any transfer, go to next negedge.
  task automatic drive(input logic [N-1:0] vld, input logic rdy, input logic push,
                       input int idx, input logic [W-1:0] d);
    exp_t e;
    for (int i = 0; i < N; i++) iReqDat[i*W +: W] = W'(8'h11 * i) ^ W'(seed);
    if (push) begin
      iReqDat[idx*W +: W] = d;
      q.push_back('{idx: IW'(idx), dat: d});
    end
    iReqVld = vld;
    iRdy    = rdy;
    seed++;
    #1;
    chk("req_rdy", 32'(oReqRdy), push ? 32'(1 << idx) : 32'd0);
    if (oVld && iRdy) begin
      chk("xfer_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt_idx", 32'(oGntIdx), 32'(e.idx));
        chk("dat", 32'(oDat), 32'(e.dat));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; iReqVld = '0; iRdy = 1'b0; iReqDat = '0;
`ifdef ZION_RR_ARB_LOCK_EN
    iReqLast = '1;
`endif
    @(negedge clk);
    chk("rst_vld", 32'(oVld), 32'd0);
    chk("rst_dat", 32'(oDat), 32'd0);
    chk("rst_idx", 32'(oGntIdx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full throughput: grants rotate 0,1,2,3,... with no bubbles
    for (int k = 0; k < 8; k++) begin
      if (k > 0) chk("tp_vld", 32'(oVld), 32'd1);
      drive(4'hF, 1'b1, 1'b1, k % 4, W'(8'h20 + k));
    end
    drive(4'h0, 1'b1, 1'b0, 0, '0);
    chk("tp_drained", 32'(oVld), 32'd0);

    // Back-pressure: hold for three cycles, then reload in the releasing cycle
    drive(4'hF, 1'b1, 1'b1, 0, 8'h30);
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, 1'b0, 1'b0, 0, '0);
      chk("bp_vld", 32'(oVld), 32'd1);
      chk("bp_idx", 32'(oGntIdx), 32'd0);
      chk("bp_dat", 32'(oDat), 32'h30);
    end
    drive(4'hF, 1'b1, 1'b1, 1, 8'h31);
    chk("bp_next_idx", 32'(oGntIdx), 32'd1);
    drive(4'h0, 1'b1, 1'b0, 0, '0);

    // Wrap-around: ptr moves to 3, then {1,3} -> 3,1, then only 1 -> 1,1
    drive(4'b0100, 1'b1, 1'b1, 2, 8'h40);
    drive(4'b1010, 1'b1, 1'b1, 3, 8'h41);
    drive(4'b1010, 1'b1, 1'b1, 1, 8'h42);
    drive(4'b0010, 1'b1, 1'b1, 1, 8'h43);
    drive(4'b0010, 1'b1, 1'b1, 1, 8'h44);
    drive(4'h0, 1'b1, 1'b0, 0, '0);

    // Drain: single word from requester 2 is valid for exactly one cycle
    drive(4'b0100, 1'b1, 1'b1, 2, 8'hA5);
    chk("drain_vld", 32'(oVld), 32'd1);
    chk("drain_dat", 32'(oDat), 32'hA5);
    chk("drain_idx", 32'(oGntIdx), 32'd2);
    drive(4'h0, 1'b1, 1'b0, 0, '0);
    chk("drain_vld_off", 32'(oVld), 32'd0);
    chk("drain_dat_hold", 32'(oDat), 32'hA5);

    // Async reset with a word in flight; pointer must return to 0 as well
    drive(4'b0010, 1'b1, 1'b1, 1, 8'h50);
    chk("pre_rst_vld", 32'(oVld), 32'd1);
    iReqVld = '0; iRdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vld", 32'(oVld), 32'd0);
    chk("async_rst_dat", 32'(oDat), 32'd0);
    chk("async_rst_idx", 32'(oGntIdx), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(4'hF, 1'b1, 1'b1, 0, 8'h60);
    drive(4'h0, 1'b1, 1'b0, 0, '0);

`ifdef ZION_RR_ARB_LOCK_EN
    // Burst lock: ptr is 1, requester 1 holds the grant for 3 beats before 0 is served
    iReqLast = 4'b1101;
    drive(4'b0011, 1'b1, 1'b1, 1, 8'h70);
    drive(4'b0011, 1'b1, 1'b1, 1, 8'h71);
    iReqLast = 4'b1111;
    drive(4'b0011, 1'b1, 1'b1, 1, 8'h72);
    drive(4'b0011, 1'b1, 1'b1, 0, 8'h73);
    drive(4'h0, 1'b1, 1'b0, 0, '0);
`endif

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
